// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter -- register-file write-back arbiter.
//
// Merges three result sources onto one register-file write port:
//   - ALU     : single-cycle results, always accepted, absolute priority
//   - load    : valid/ready handshake, round-robin with mul/div
//   - mul/div : valid/ready handshake, round-robin with load
// The accepted result is registered and presented for one cycle on
// writeEn/writeAddr/writeData. The register file captures it on the falling
// edge inside that cycle. Results addressed to x0 complete their handshake
// but never assert writeEn.
//
// Optional feature (compile-time macro WB_SCOREBOARD_EN):
//   When defined, a 32-entry pending-destination scoreboard is built. An
//   issued long-latency op sets busy[issueAddr]. A completed load or mul/div
//   handshake clears busy[addr]. When both hit the same register in the same
//   cycle, the set wins. When the macro is undefined, busy is tied to zero
//   and issueValid/issueAddr are ignored.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   aluValid/aluAddr/aluData   ALU result (no back-pressure)
//   ldValid/ldReady/ldAddr/ldData   load result handshake
//   mdValid/mdReady/mdAddr/mdData   mul/div result handshake
//   issueValid/issueAddr       long-latency op issue (scoreboard set)
//   busy                       pending-destination scoreboard
//   writeEn/writeAddr/writeData     registered register-file write port
// ---------------------------------------------------------------------------
module wb_arbiter (
  input  logic        clk,
  input  logic        rst,
  // ALU source
  input  logic        aluValid,
  input  logic [4:0]  aluAddr,
  input  logic [31:0] aluData,
  // Load source
  input  logic        ldValid,
  output logic        ldReady,
  input  logic [4:0]  ldAddr,
  input  logic [31:0] ldData,
  // Mul/div source
  input  logic        mdValid,
  output logic        mdReady,
  input  logic [4:0]  mdAddr,
  input  logic [31:0] mdData,
  // Issue tracking
  input  logic        issueValid,
  input  logic [4:0]  issueAddr,
  output logic [31:0] busy,
  // Register-file write port
  output logic        writeEn,
  output logic [4:0]  writeAddr,
  output logic [31:0] writeData
);

  // Round-robin pointer: 0 favours load, 1 favours mul/div.
  localparam logic RrLd = 1'b0;
  localparam logic RrMd = 1'b1;

  logic        rr_q, rr_d;
  logic        write_en_q, write_en_d;
  logic [4:0]  write_addr_q, write_addr_d;
  logic [31:0] write_data_q, write_data_d;

  logic        ld_ready, md_ready;
  logic        ld_hs, md_hs;

  // -------------------------------------------------------------------------
  // Secondary-source grant
  // -------------------------------------------------------------------------
  // A secondary source wins when the ALU is idle and it is either the only
  // requester or the one the pointer favours. The two terms are mutually
  // exclusive by construction, so at most one ready is ever high.
  always_comb begin
    ld_ready = 1'b0;
    md_ready = 1'b0;
    if (!rst && !aluValid) begin
      ld_ready = ldValid && (!mdValid || (rr_q == RrLd));
      md_ready = mdValid && (!ldValid || (rr_q == RrMd));
    end
  end

  assign ldReady = ld_ready;
  assign mdReady = md_ready;

  assign ld_hs = ldValid && ld_ready;
  assign md_hs = mdValid && md_ready;

  // -------------------------------------------------------------------------
  // Round-robin pointer: moves only on a completed secondary handshake, and
  // points away from the source just granted.
  // -------------------------------------------------------------------------
  always_comb begin
    rr_d = rr_q;
    if (ld_hs) begin
      rr_d = RrMd;
    end else if (md_hs) begin
      rr_d = RrLd;
    end
  end

  // -------------------------------------------------------------------------
  // Write-port next state
  // -------------------------------------------------------------------------
  // Without an accepted result writeEn drops and addr/data hold their values.
  // An accepted x0 result still updates addr/data but does not write.
  always_comb begin
    write_en_d   = 1'b0;
    write_addr_d = write_addr_q;
    write_data_d = write_data_q;
    if (aluValid) begin
      write_en_d   = (aluAddr != 5'd0);
      write_addr_d = aluAddr;
      write_data_d = aluData;
    end else if (ld_hs) begin
      write_en_d   = (ldAddr != 5'd0);
      write_addr_d = ldAddr;
      write_data_d = ldData;
    end else if (md_hs) begin
      write_en_d   = (mdAddr != 5'd0);
      write_addr_d = mdAddr;
      write_data_d = mdData;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q         <= RrLd;
      write_en_q   <= 1'b0;
      write_addr_q <= 5'd0;
      write_data_q <= 32'd0;
    end else begin
      rr_q         <= rr_d;
      write_en_q   <= write_en_d;
      write_addr_q <= write_addr_d;
      write_data_q <= write_data_d;
    end
  end

  assign writeEn   = write_en_q;
  assign writeAddr = write_addr_q;
  assign writeData = write_data_q;

  // -------------------------------------------------------------------------
  // Pending-destination scoreboard
  // -------------------------------------------------------------------------
`ifdef WB_SCOREBOARD_EN
  logic [31:0] busy_q, busy_d;

  // Clear first, then set, so a same-cycle set on the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (ld_hs) begin
      busy_d[ldAddr] = 1'b0;
    end
    if (md_hs) begin
      busy_d[mdAddr] = 1'b0;
    end
    if (issueValid && (issueAddr != 5'd0)) begin
      busy_d[issueAddr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 32'd0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
`else
  // Issue inputs have no function in this build.
  logic unused_issue;
  assign unused_issue = ^{issueValid, issueAddr};
  assign busy         = 32'h0;
`endif

endmodule
